load_store_sequencer: RTL
=========================

# load_store_sequencer

Multicycle memory-access sequencer for the datapath's load/store instructions (LW, LH, LB, SW, SH, SB). It drives the shared memory port, owns the memory data register, and performs read-modify-write for sub-word stores. Sub-word stores replace the low-order 16 or 8 bits of the addressed word. Sub-word loads zero-extend the low-order bits. It sits between the control unit / A+offset address path and the memory, and feeds the register-file write-back mux.

## Interface
Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal 1..3).

Ports:
- clk  in  1  system clock; only clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only when busy=0
- op  in  3  0=LW, 1=LH, 2=LB, 4=SW, 5=SH, 6=SB; 3 and 7 are illegal
- addr  in  32  byte address (base + offset from datapath)
- store_data  in  32  B-register value
- mem_rdata  in  32  memory read data
- mem_addr  out  32  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mdr  out  32  memory data register (raw last word read)
- load_data  out  32  zero-extended load result; held until next load completes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on illegal or misaligned request

## Operation
- States: IDLE, RD_WAIT, WRITE, FINISH.
- IDLE:
  - start=1 latches op, addr and store_data.
  - Illegal op or misalignment → FINISH with err_pending set; no memory access.
  - Misaligned means word op with addr[1:0]≠0, or half op with addr[0]≠0.
  - SW → WRITE. All others → RD_WAIT with the wait counter set to MEM_LAT-1.
- RD_WAIT:
  - mem_addr = {latched addr[31:2],2'b00}, mem_wr=0.
  - Counter decrements each cycle.
  - On the edge leaving the state (counter=0): mdr←mem_rdata.
  - On that same edge, for loads: load_data←LW: mem_rdata; LH: {16'b0,mem_rdata[15:0]}; LB: {24'b0,mem_rdata[7:0]}.
  - Loads → FINISH. SH/SB → WRITE.
- WRITE:
  - mem_wr=1 for exactly one cycle; mem_addr as in RD_WAIT.
  - mem_wdata: SW → store_data; SH → {mdr[31:16],store_data[15:0]}; SB → {mdr[31:8],store_data[7:0]}.
  - → FINISH.
- FINISH: done=1; err=err_pending; → IDLE.
- Outside RD_WAIT/WRITE: mem_addr=0, mem_wr=0, mem_wdata=0.
- start while busy=1 (including FINISH) is ignored; no queuing.
- Stores never modify load_data. mdr changes only on a read capture.

## Timing
- Reset values: state IDLE; mem_addr, mem_wr, mem_wdata, mdr, load_data, busy, done, err all 0; counter 0.
- Reset asserted in any state: next edge forces IDLE and all reset values. A WRITE in progress drops mem_wr on that edge; an in-flight read is discarded with mdr=0.
- Cycle numbering: start accepted at the edge ending cycle 0.
- Completion latency:
  - SW: WRITE in cycle 1; done in cycle 2.
  - Loads: RD_WAIT in cycles 1..MEM_LAT; done in cycle MEM_LAT+1, with load_data valid in that cycle.
  - SH/SB: WRITE in cycle MEM_LAT+1; done in cycle MEM_LAT+2.
  - Illegal/misaligned: done=err=1 in cycle 1.
- Back-to-back: the next start is accepted earliest in the first IDLE cycle after done (cycle after FINISH).
- All outputs are decoded from registered state and registers. mem_rdata is used only at the RD_WAIT exit edge; there is no combinational path from start to mem_*.

## Structure
- Package ls_pkg holds:
  - op codes OP_LW..OP_SB
  - state encoding (2-bit enum IDLE=0, RD_WAIT=1, WRITE=2, FINISH=3)
  - the helper constants LANE_HALF=16 and LANE_BYTE=8
- One combinational sub-module, store_lane_merge (op, mdr, store_data → mem_wdata), shared with any future lane logic. FSM, counter and registers stay in the top.

## Test plan
- Reset then SW: addr=0x0000_0010, store_data=0xDEAD_BEEF → mem_wr=1 in cycle 1 with mem_addr=0x10, mem_wdata=0xDEADBEEF; done in cycle 2; load_data stays 0.
- MEM_LAT=2, LB: addr 0x20, mem_rdata=0x1234_56F0 → mem_wr=0 in cycles 1-2; done in cycle 3; load_data=0x0000_00F0; mdr=0x123456F0.
- SH: addr 0x24, mem_rdata=0xAAAA_BBBB, store_data=0x0000_1357 (MEM_LAT=1) → WRITE in cycle 2 with mem_wdata=0xAAAA_1357; done in cycle 3.
- Illegal op=3, and LW at addr 0x2 → done=err=1 in cycle 1; mem_wr never asserted; mem_addr stays 0.
- start held high through an LH: exactly one transaction; a second is accepted only in the cycle after done.
- Reset asserted during WRITE of an SB → mem_wr=0 and busy=0 the next cycle; all outputs at reset values; no done pulse.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the op encodings, the sequencer state encoding, lane widths for
// sub-word accesses and the load zero-extension helper.
package ls_pkg;

  localparam logic [2:0] OP_LW = 3'd0;
  localparam logic [2:0] OP_LH = 3'd1;
  localparam logic [2:0] OP_LB = 3'd2;
  localparam logic [2:0] OP_SW = 3'd4;
  localparam logic [2:0] OP_SH = 3'd5;
  localparam logic [2:0] OP_SB = 3'd6;

  localparam int unsigned LANE_HALF = 16;
  localparam int unsigned LANE_BYTE = 8;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 3.
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // Zero-extend the low-order lane of a fetched word for a load op.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] word);
    logic [31:0] res;
    res = word;
    if (op == OP_LH) begin
      res = {{(32 - LANE_HALF){1'b0}}, word[LANE_HALF-1:0]};
    end else if (op == OP_LB) begin
      res = {{(32 - LANE_BYTE){1'b0}}, word[LANE_BYTE-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Store lane merge: builds the word written to memory.
// Full-word stores pass store_data through; sub-word stores keep the upper
// bits of the previously read word (mdr) and replace the low-order lane.
// Ports:
//   op         - latched opcode
//   mdr        - word read during the read-modify-write
//   store_data - register value being stored
//   mem_wdata  - merged write word
module store_lane_merge
  import ls_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] mdr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_wdata
);

  always_comb begin
    mem_wdata = store_data;
    if (op == OP_SH) begin
      mem_wdata = {mdr[31:LANE_HALF], store_data[LANE_HALF-1:0]};
    end else if (op == OP_SB) begin
      mem_wdata = {mdr[31:LANE_BYTE], store_data[LANE_BYTE-1:0]};
    end
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer (LW/LH/LB/SW/SH/SB).
// Drives the shared memory port, owns the memory data register and performs
// read-modify-write for sub-word stores. All outputs decode from registers.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   start, op, addr      - request (sampled only while idle)
//   store_data           - value to store
//   mem_rdata            - memory read data
//   mem_addr/wr/wdata    - memory port (zero outside RD_WAIT/WRITE)
//   mdr                  - raw last word read
//   load_data            - zero-extended result of the last completed load
//   busy, done, err      - status; done/err are one-cycle pulses
module load_store_sequencer
  import ls_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mdr,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:2]      waddr_q, waddr_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             errp_q, errp_d;
  logic [31:0]      mdr_q, mdr_d;
  logic [31:0]      ld_q, ld_d;
  logic [31:0]      merged;
  logic             req_bad;

  // Illegal opcode (x11) or misaligned word/half access.
  always_comb begin
    req_bad = 1'b0;
    if (op[1:0] == 2'b11) begin
      req_bad = 1'b1;
    end else if (op[1:0] == 2'b00) begin
      req_bad = (addr[1:0] != 2'b00);
    end else if (op[1:0] == 2'b01) begin
      req_bad = addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      waddr_q <= '0;
      sdata_q <= '0;
      errp_q  <= 1'b0;
      mdr_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      sdata_q <= sdata_d;
      errp_q  <= errp_d;
      mdr_q   <= mdr_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    sdata_d = sdata_q;
    errp_d  = errp_q;
    mdr_d   = mdr_q;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          waddr_d = addr[31:2];
          sdata_d = store_data;
          errp_d  = req_bad;
          cnt_d   = CntInit;
          if (req_bad) begin
            state_d = FINISH;
          end else if (op == OP_SW) begin
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          mdr_d = mem_rdata;
          // op[2] set means a store; only loads update load_data.
          if (!op_q[2]) begin
            ld_d    = load_extend(op_q, mem_rdata);
            state_d = FINISH;
          end else begin
            state_d = WRITE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        state_d = FINISH;
      end
      FINISH: begin
        errp_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  store_lane_merge u_merge (
    .op        (op_q),
    .mdr       (mdr_q),
    .store_data(sdata_q),
    .mem_wdata (merged)
  );

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
    err       = (state_q == FINISH) && errp_q;
    mem_wr    = (state_q == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == RD_WAIT || state_q == WRITE) begin
      mem_addr = {waddr_q, 2'b00};
    end
    if (state_q == WRITE) begin
      mem_wdata = merged;
    end
    mdr       = mdr_q;
    load_data = ld_q;
  end

endmodule
